// File: rtl/shift_register_stream_load_pkg.sv
// Shared sizing helpers for the stream-load shift register.
// Count width and thermometer lane masks.
package ShiftRegisterPkg;

    localparam int MAX_LANES = 64;

    function automatic int countWidth(input int depth);
        return $clog2(depth + 1);
    endfunction

    function automatic logic [MAX_LANES-1:0] laneMask(
        input int count,
        input int lanes
    );
        logic [MAX_LANES-1:0] m;
        m = '0;
        for (int i = 0; i < MAX_LANES; i++) begin
            m[i] = (i < count) && (i < lanes);
        end
        return m;
    endfunction

endpackage

// File: rtl/shift_register_stream_load_if.sv
// Load and drain bus of the stream-load shift register.
// master drives load/init/outReady; slave is the register block.
interface shift_register_stream_load_if
    import ShiftRegisterPkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LANES = 1
);
    localparam int CW = countWidth(DEPTH);

    logic [DEPTH-1:0][WIDTH-1:0] init;
    logic [CW-1:0]               initCount;
    logic                        load;
    logic                        loadReady;
    logic [LANES-1:0][WIDTH-1:0] outData;
    logic [LANES-1:0]            outLaneValid;
    logic                        outValid;
    logic                        outReady;
    logic                        outLast;
    logic [CW-1:0]               count;
    logic                        overrun;

    modport master (
        output init, initCount, load, outReady,
        input  loadReady, outData, outLaneValid,
        input  outValid, outLast, count, overrun
    );

    modport slave (
        input  init, initCount, load, outReady,
        output loadReady, outData, outLaneValid,
        output outValid, outLast, count, overrun
    );

endinterface

// File: rtl/shift_register_stream_load_lane_mask.sv
// Count to per-lane valid mask plus final-beat flag.
// Also used at DEPTH width to zero unused words of a load image.
module shift_register_lane_mask
    import ShiftRegisterPkg::*;
#(
    parameter int LANES = 1,
    parameter int CW    = 3
) (
    input  logic [CW-1:0]    i_count,
    output logic [LANES-1:0] o_laneValid,
    output logic             o_last
);

    assign o_laneValid = LANES'(laneMask(int'(i_count), LANES));
    assign o_last      = (i_count != '0) && (int'(i_count) <= LANES);

endmodule

// File: rtl/shift_register_stream_load.sv
// Parallel-load shift register draining LANES words per beat.
// A final-beat fire and a new load may share a cycle with no bubble.
module shift_register_stream_load
    import ShiftRegisterPkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    parameter int LANES = 1
) (
    input logic                          i_clock,
    input logic                          i_reset,
    shift_register_stream_load_if.slave  bus
);

    localparam int            CW      = countWidth(DEPTH);
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] LANES_C = CW'(LANES);

    logic [DEPTH-1:0][WIDTH-1:0] r_regs;
    logic [DEPTH-1:0][WIDTH-1:0] w_regsNext;
    logic [DEPTH-1:0][WIDTH-1:0] w_shifted;
    logic [DEPTH-1:0][WIDTH-1:0] w_loadImg;
    logic [CW-1:0]               r_count;
    logic [CW-1:0]               w_countNext;
    logic [CW-1:0]               w_initSat;
    logic [CW-1:0]               w_countDec;
    logic                        r_overrun;
    logic                        w_overrunNext;
    logic                        w_outValid;
    logic                        w_outLast;
    logic                        w_fire;
    logic                        w_accept;
    logic                        w_loadReady;
    logic [DEPTH-1:0]            w_loadMask;
    logic                        w_loadNonEmpty;

    shift_register_lane_mask #(
        .LANES (LANES),
        .CW    (CW)
    ) u_out_mask (
        .i_count     (r_count),
        .o_laneValid (bus.outLaneValid),
        .o_last      (w_outLast)
    );

    shift_register_lane_mask #(
        .LANES (DEPTH),
        .CW    (CW)
    ) u_load_mask (
        .i_count     (w_initSat),
        .o_laneValid (w_loadMask),
        .o_last      (w_loadNonEmpty)
    );

    assign w_initSat   = (bus.initCount > DEPTH_C) ? DEPTH_C : bus.initCount;
    assign w_countDec  = (r_count > LANES_C) ? (r_count - LANES_C) : '0;
    assign w_outValid  = (r_count != '0);
    assign w_fire      = w_outValid && bus.outReady;
    assign w_loadReady = (r_count == '0) || (w_fire && w_outLast);
    assign w_accept    = bus.load && w_loadReady;

    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign w_loadImg[i] = w_loadMask[i] ? bus.init[i] : '0;
        if (i + LANES < DEPTH) begin : g_mid
            assign w_shifted[i] = r_regs[i + LANES];
        end else begin : g_top
            assign w_shifted[i] = '0;
        end
    end

    always_comb begin
        w_regsNext    = r_regs;
        w_countNext   = r_count;
        w_overrunNext = r_overrun | (bus.load && !w_loadReady);
        if (w_accept) begin
            w_regsNext  = w_loadImg;
            w_countNext = w_loadNonEmpty ? w_initSat : '0;
        end else if (w_fire) begin
            w_regsNext  = w_shifted;
            w_countNext = w_countDec;
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_regs    <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_regs    <= w_regsNext;
            r_count   <= w_countNext;
            r_overrun <= w_overrunNext;
        end
    end

    assign bus.outData   = r_regs[LANES-1:0];
    assign bus.outValid  = w_outValid;
    assign bus.outLast   = w_outLast;
    assign bus.loadReady = w_loadReady;
    assign bus.count     = r_count;
    assign bus.overrun   = r_overrun;

endmodule
